matrix_slot_allocator: RTL and testbench
========================================

# matrix_slot_allocator

Parametrised storage manager for the matrix memory. It keeps a table of matrix dimension types and gives each type `SLOTS` consecutive slots, which it reuses in rotation (ping-pong generalised to N-way). The input path asks it for the base write address of each new matrix. The display and calculation paths query it for the address of any stored matrix. It sits between FSM_Controller/Input_Subsystem and Matrix_storage, and replaces fixed two-slot addressing.

## Interface
- `DIM_W`, 3: width of the m/n dimension fields.
- `MAX_DIM`, 5: largest legal m or n.
- `MAX_TYPES`, 8: number of dimension-type table entries.
- `SLOTS`, 2: slots per type (N-way rotation), ≥1.
- `ADDR_W`, 8: storage address width; memory depth is 2^ADDR_W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: allocation request; sampled only in IDLE.
- `i_dim_m`, `i_dim_n` in DIM_W: requested dimensions, sampled with `i_req`.
- `i_commit` in 1: matrix fully written; make the allocation permanent.
- `i_abort` in 1: input failed; discard the allocation.
- `i_clear` in 1: wipe the table; honoured in IDLE only.
- `o_ready` out 1: high in IDLE.
- `o_grant` out 1: high for the whole GRANT state.
- `o_base_addr` out ADDR_W: granted write base; stable while `o_grant` is high.
- `o_type_idx` out $clog2(MAX_TYPES): type index of the grant.
- `o_slot_idx` out $clog2(SLOTS): slot index of the grant.
- `o_error` out 1: one-cycle error pulse.
- `o_err_code` out 2: 1 = bad dimensions, 2 = table full, 3 = memory exhausted; held until the next request.
- `o_type_count` out $clog2(MAX_TYPES)+1: number of committed types.
- `i_q_type` in $clog2(MAX_TYPES), `i_q_slot` in $clog2(SLOTS): query inputs.
- `o_q_addr` out ADDR_W: base address for the queried type and slot.
- `o_q_m`, `o_q_n` out DIM_W: dimensions of the queried type.
- `o_q_valid` out 1: queried slot holds committed data.

## Operation
- Table entry fields: m, n, base (ADDR_W), size = m·n, next_slot pointer, SLOTS valid bits.
- A global free pointer (ADDR_W+1 bits) marks the first unallocated address.
- States: IDLE, SCAN, ALLOC, GRANT, ERR.
- IDLE:
  - `i_req` latches the dimensions.
  - If m or n is 0 or greater than MAX_DIM, go to ERR with code 1.
  - Otherwise go to SCAN with scan_idx = 0.
  - `i_clear` without `i_req` resets type_count, free pointer and all valid bits. `i_req` wins over a simultaneous `i_clear`.
- SCAN compares one entry per cycle.
  - If entry[scan_idx] matches m and n, go to GRANT with that type and slot = next_slot.
  - If scan_idx == type_count, it is a miss: go to ALLOC.
- ALLOC:
  - If type_count == MAX_TYPES, go to ERR with code 2.
  - Else if free + SLOTS·m·n > 2^ADDR_W, go to ERR with code 3.
  - Otherwise prepare a pending new entry with base = free and slot 0, then go to GRANT.
  - The table and free pointer are not modified yet.
- GRANT:
  - o_base_addr = base + slot·size, truncated to ADDR_W. It never overflows because ALLOC checked the bound.
  - `i_commit`: set the slot valid bit and advance next_slot = (slot+1) mod SLOTS. For a new type, write the entry, increment type_count, and add SLOTS·size to free. Return to IDLE.
  - `i_abort`: return to IDLE with no state change.
  - Commit and abort in the same cycle: abort wins.
  - There is no timeout.
- ERR: pulse `o_error` for one cycle, then return to IDLE. The table is untouched.
- Rotation: when next_slot wraps, the oldest slot is overwritten; its valid bit stays set.
- Query path:
  - Registered, with 1-cycle latency, and independent of the FSM state.
  - o_q_valid = (i_q_type < type_count) & valid[i_q_type][i_q_slot].
  - o_q_addr, o_q_m and o_q_n are 0 when the queried type is out of range.
- Arithmetic:
  - m·n is computed at 2·DIM_W bits.
  - SLOTS·size and the free-pointer sum are computed at ADDR_W+2 bits.
  - The memory-exhausted compare happens before truncation.

## Timing
- Reset: every output is 0 except `o_ready` = 1. The state goes to IDLE, and type_count, free pointer and all valid bits are cleared. Asserting reset mid-operation aborts it with no residual state.
- Edge numbering: edge 0 is the one that samples `i_req`.
- Hit on entry j: `o_grant` is high after edge j+1.
- Miss: `o_grant` is high after edge type_count+2.
- Bad dimensions: `o_error` is high after edge 0, for one cycle.
- Table full or memory exhausted: `o_error` is high after edge type_count+2.
- Commit or abort sampled at an edge: `o_ready` is high after that edge, and the updated table is visible to a query issued in the same cycle.
- `i_req` while `o_ready` is low is ignored. It is not queued.

## Test plan
- Defaults, new type: req 2×2, commit → base 0, type 0, slot 0, type_count 1, free 8, grant after edge 2.
- Second new type, then rotation: req 2×3, commit → base 8, type 1. Then req 2×2 → base 4, slot 1, grant after edge 1. Then req 2×2 → base 0, slot 0 (wrap).
- Abort on a new type: req 3×3, abort → type_count unchanged, free unchanged. Retry 3×3, commit → base 20.
- Errors: req 0×2 → code 1, pulse after edge 0. Fill 8 types, then a 9th new dimension → code 2. Request 5×5 with SLOTS=2 when free = 220 → code 3. In every case the table is unchanged.
- Query: after the rotation case, query (0,1) → one cycle later addr 4, m = n = 2, valid 1. Query (5,0) → valid 0, addr 0.
- Reset during GRANT, and commit+abort in the same cycle: reset → all outputs at reset values and a query returns valid 0. Simultaneous commit and abort → treated as abort.

Source files
------------

// File: rtl/matrix_slot_allocator.sv
// matrix_slot_allocator
//   Storage manager for the matrix memory. Keeps a table of matrix dimension
//   types; each type owns SLOTS consecutive slots of m*n words, handed out in
//   rotation. The input path requests a write base per new matrix, and the
//   display/calculation paths look up stored matrices through the query port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req, i_dim_m/n      allocation request with dimensions (taken in IDLE)
//   i_commit, i_abort     finish the current grant (abort wins)
//   i_clear               wipe the table (IDLE only, i_req has priority)
//   o_ready               FSM is idle and will accept i_req
//   o_grant               allocation granted; o_base_addr/o_type_idx/o_slot_idx valid
//   o_error, o_err_code   one-cycle error pulse; code 1 bad dims, 2 table full,
//                         3 memory exhausted (code held until next request)
//   o_type_count          number of committed types
//   i_q_type, i_q_slot    query select; o_q_* respond one cycle later
//   dbg_state             current FSM state for debug/checkers
//
// Handshake: a request is accepted on any rising edge where o_ready and i_req
// are both high; i_req at any other time is dropped, never queued. Once
// o_grant rises it stays high, with stable address fields, until the edge
// that samples i_commit or i_abort; o_ready is high right after that edge.
module matrix_slot_allocator #(
   parameter int DIM_W     = 3,
   parameter int MAX_DIM   = 5,
   parameter int MAX_TYPES = 8,
   parameter int SLOTS     = 2,
   parameter int ADDR_W    = 8,
   localparam int TW = (MAX_TYPES > 1) ? $clog2(MAX_TYPES) : 1,
   localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [DIM_W-1:0]  i_dim_m,
   input  logic [DIM_W-1:0]  i_dim_n,
   input  logic              i_commit,
   input  logic              i_abort,
   input  logic              i_clear,
   output logic              o_ready,
   output logic              o_grant,
   output logic [ADDR_W-1:0] o_base_addr,
   output logic [TW-1:0]     o_type_idx,
   output logic [SW-1:0]     o_slot_idx,
   output logic              o_error,
   output logic [1:0]        o_err_code,
   output logic [TW:0]       o_type_count,
   input  logic [TW-1:0]     i_q_type,
   input  logic [SW-1:0]     i_q_slot,
   output logic [ADDR_W-1:0] o_q_addr,
   output logic [DIM_W-1:0]  o_q_m,
   output logic [DIM_W-1:0]  o_q_n,
   output logic              o_q_valid,
   output logic [2:0]        dbg_state
);

   localparam int SZW = 2 * DIM_W;   // width of m*n
   localparam int XW  = ADDR_W + 2;  // width of address sums before truncation

   localparam logic [XW-1:0]    MEM_DEPTH = {2'b01, {ADDR_W{1'b0}}};
   localparam logic [XW-1:0]    SLOTS_X   = XW'(SLOTS);
   localparam logic [TW:0]      MAX_T     = (TW+1)'(MAX_TYPES);
   localparam logic [DIM_W-1:0] MAXD      = DIM_W'(MAX_DIM);
   localparam bit               SLOT_POW2 = (SLOTS == (1 << SW));

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_ALLOC = 3'd2,
      S_GRANT = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t state;

   // Type table
   logic [DIM_W-1:0]  ent_m     [MAX_TYPES];
   logic [DIM_W-1:0]  ent_n     [MAX_TYPES];
   logic [ADDR_W-1:0] ent_base  [MAX_TYPES];
   logic [SZW-1:0]    ent_size  [MAX_TYPES];
   logic [SW-1:0]     ent_next  [MAX_TYPES];
   logic [SLOTS-1:0]  ent_valid [MAX_TYPES];

   logic [TW:0]       type_count;
   logic [ADDR_W:0]   free_ptr;

   // Latched request and pending grant
   logic [DIM_W-1:0]  req_m;
   logic [DIM_W-1:0]  req_n;
   logic [SZW-1:0]    req_size;
   logic [TW:0]       scan_idx;
   logic [TW-1:0]     g_type;
   logic [SW-1:0]     g_slot;
   logic              g_new;

   function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [SW-1:0]     slot,
                                                   input logic [SZW-1:0]    size);
      return ADDR_W'(XW'(base) + XW'(slot) * XW'(size));
   endfunction

   function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] slot);
      return (slot == SW'(SLOTS - 1)) ? '0 : slot + SW'(1);
   endfunction

   logic [TW-1:0] s_i;
   logic          scan_hit;
   logic [XW-1:0] need_x;
   logic [XW-1:0] free_sum;
   logic          bad_dims;
   logic          q_type_ok;
   logic          q_slot_ok;

   always_comb begin
      s_i       = scan_idx[TW-1:0];
      scan_hit  = (ent_m[s_i] == req_m) && (ent_n[s_i] == req_n);
      need_x    = SLOTS_X * XW'(req_size);
      // exhaustion is judged on the untruncated sum
      free_sum  = XW'(free_ptr) + need_x;
      bad_dims  = (i_dim_m == '0) || (i_dim_n == '0) || (i_dim_m > MAXD) || (i_dim_n > MAXD);
      q_type_ok = ({1'b0, i_q_type} < type_count);
      q_slot_ok = SLOT_POW2 || (int'(i_q_slot) < SLOTS);
   end

   assign o_type_count = type_count;
   assign dbg_state    = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         o_ready     <= 1'b1;
         o_grant     <= 1'b0;
         o_base_addr <= '0;
         o_type_idx  <= '0;
         o_slot_idx  <= '0;
         o_error     <= 1'b0;
         o_err_code  <= '0;
         type_count  <= '0;
         free_ptr    <= '0;
         req_m       <= '0;
         req_n       <= '0;
         req_size    <= '0;
         scan_idx    <= '0;
         g_type      <= '0;
         g_slot      <= '0;
         g_new       <= 1'b0;
         for (int i = 0; i < MAX_TYPES; i++) begin
            ent_m[i]     <= '0;
            ent_n[i]     <= '0;
            ent_base[i]  <= '0;
            ent_size[i]  <= '0;
            ent_next[i]  <= '0;
            ent_valid[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (i_req) begin
                  req_m      <= i_dim_m;
                  req_n      <= i_dim_n;
                  req_size   <= SZW'(i_dim_m) * SZW'(i_dim_n);
                  scan_idx   <= '0;
                  o_ready    <= 1'b0;
                  if (bad_dims) begin
                     state      <= S_ERR;
                     o_error    <= 1'b1;
                     o_err_code <= 2'd1;
                  end else begin
                     state      <= S_SCAN;
                     o_err_code <= 2'd0;
                  end
               end else if (i_clear) begin
                  type_count <= '0;
                  free_ptr   <= '0;
                  for (int i = 0; i < MAX_TYPES; i++) begin
                     ent_valid[i] <= '0;
                  end
               end
            end

            S_SCAN: begin
               // miss test first: entries at or beyond type_count are stale
               if (scan_idx == type_count) begin
                  state <= S_ALLOC;
               end else if (scan_hit) begin
                  state       <= S_GRANT;
                  g_type      <= s_i;
                  g_slot      <= ent_next[s_i];
                  g_new       <= 1'b0;
                  o_grant     <= 1'b1;
                  o_base_addr <= slot_addr(ent_base[s_i], ent_next[s_i], ent_size[s_i]);
                  o_type_idx  <= s_i;
                  o_slot_idx  <= ent_next[s_i];
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end

            S_ALLOC: begin
               if (type_count == MAX_T) begin
                  state      <= S_ERR;
                  o_error    <= 1'b1;
                  o_err_code <= 2'd2;
               end else if (free_sum > MEM_DEPTH) begin
                  state      <= S_ERR;
                  o_error    <= 1'b1;
                  o_err_code <= 2'd3;
               end else begin
                  // pending entry only; the table is written on commit
                  state       <= S_GRANT;
                  g_type      <= type_count[TW-1:0];
                  g_slot      <= '0;
                  g_new       <= 1'b1;
                  o_grant     <= 1'b1;
                  o_base_addr <= free_ptr[ADDR_W-1:0];
                  o_type_idx  <= type_count[TW-1:0];
                  o_slot_idx  <= '0;
               end
            end

            S_GRANT: begin
               if (i_abort) begin
                  state   <= S_IDLE;
                  o_grant <= 1'b0;
                  o_ready <= 1'b1;
               end else if (i_commit) begin
                  state   <= S_IDLE;
                  o_grant <= 1'b0;
                  o_ready <= 1'b1;
                  ent_next[g_type] <= slot_inc(g_slot);
                  if (g_new) begin
                     ent_m[g_type]     <= req_m;
                     ent_n[g_type]     <= req_n;
                     ent_base[g_type]  <= free_ptr[ADDR_W-1:0];
                     ent_size[g_type]  <= req_size;
                     ent_valid[g_type] <= SLOTS'(1);
                     type_count        <= type_count + 1'b1;
                     free_ptr          <= free_ptr + (ADDR_W+1)'(need_x);
                  end else begin
                     ent_valid[g_type][g_slot] <= 1'b1;
                  end
               end
            end

            S_ERR: begin
               state   <= S_IDLE;
               o_error <= 1'b0;
               o_ready <= 1'b1;
            end

            default: begin
               state   <= S_IDLE;
               o_grant <= 1'b0;
               o_error <= 1'b0;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

   // Query port: one-cycle registered lookup, independent of the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q_addr  <= '0;
         o_q_m     <= '0;
         o_q_n     <= '0;
         o_q_valid <= 1'b0;
      end else if (q_type_ok) begin
         o_q_addr  <= slot_addr(ent_base[i_q_type], i_q_slot, ent_size[i_q_type]);
         o_q_m     <= ent_m[i_q_type];
         o_q_n     <= ent_n[i_q_type];
         o_q_valid <= q_slot_ok & ent_valid[i_q_type][i_q_slot];
      end else begin
         o_q_addr  <= '0;
         o_q_m     <= '0;
         o_q_n     <= '0;
         o_q_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Testbench for matrix_slot_allocator: directed scenarios followed by random
// requests/queries, checked against a table model kept as plain arrays.
module tb_matrix_slot_allocator;

   localparam int DIM_W     = 3;
   localparam int MAX_DIM   = 5;
   localparam int MAX_TYPES = 8;
   localparam int SLOTS     = 2;
   localparam int ADDR_W    = 8;
   localparam int TW        = 3;
   localparam int SW        = 1;
   localparam int MEM       = 1 << ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              i_req, i_commit, i_abort, i_clear;
   logic [DIM_W-1:0]  i_dim_m, i_dim_n;
   logic              o_ready, o_grant, o_error, o_q_valid;
   logic [ADDR_W-1:0] o_base_addr, o_q_addr;
   logic [TW-1:0]     o_type_idx, i_q_type;
   logic [SW-1:0]     o_slot_idx, i_q_slot;
   logic [1:0]        o_err_code;
   logic [TW:0]       o_type_count;
   logic [DIM_W-1:0]  o_q_m, o_q_n;
   logic [2:0]        dbg_state;

   matrix_slot_allocator #(
      .DIM_W(DIM_W), .MAX_DIM(MAX_DIM), .MAX_TYPES(MAX_TYPES),
      .SLOTS(SLOTS), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_dim_m(i_dim_m), .i_dim_n(i_dim_n),
      .i_commit(i_commit), .i_abort(i_abort), .i_clear(i_clear),
      .o_ready(o_ready), .o_grant(o_grant), .o_base_addr(o_base_addr),
      .o_type_idx(o_type_idx), .o_slot_idx(o_slot_idx),
      .o_error(o_error), .o_err_code(o_err_code), .o_type_count(o_type_count),
      .i_q_type(i_q_type), .i_q_slot(i_q_slot),
      .o_q_addr(o_q_addr), .o_q_m(o_q_m), .o_q_n(o_q_n), .o_q_valid(o_q_valid),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int mt_m    [MAX_TYPES];
   int mt_n    [MAX_TYPES];
   int mt_base [MAX_TYPES];
   int mt_next [MAX_TYPES];
   bit mt_valid[MAX_TYPES][SLOTS];
   int m_count;
   int m_free;

   task automatic model_clear();
      m_count = 0;
      m_free  = 0;
      for (int i = 0; i < MAX_TYPES; i++)
         for (int j = 0; j < SLOTS; j++) mt_valid[i][j] = 1'b0;
   endtask

   // kind: 0 new type, 1 hit, 2 error
   task automatic predict(input int m, input int n, output int kind, output int code,
                          output int lat, output int t, output int s, output int addr);
      kind = 2; code = 0; lat = 0; t = 0; s = 0; addr = 0;
      if (m == 0 || n == 0 || m > MAX_DIM || n > MAX_DIM) begin
         code = 1;
         return;
      end
      for (int j = 0; j < m_count; j++) begin
         if (mt_m[j] == m && mt_n[j] == n) begin
            kind = 1; t = j; s = mt_next[j];
            addr = (mt_base[j] + s * m * n) % MEM;
            lat  = j + 1;
            return;
         end
      end
      lat = m_count + 2;
      if (m_count == MAX_TYPES) code = 2;
      else if (m_free + SLOTS * m * n > MEM) code = 3;
      else begin
         kind = 0; t = m_count; s = 0; addr = m_free;
      end
   endtask

   task automatic model_commit(input int kind, input int m, input int n, input int t, input int s);
      if (kind == 0) begin
         mt_m[t] = m; mt_n[t] = n; mt_base[t] = m_free;
         for (int j = 0; j < SLOTS; j++) mt_valid[t][j] = (j == 0);
         mt_next[t] = 1 % SLOTS;
         m_count++;
         m_free += SLOTS * m * n;
      end else begin
         mt_valid[t][s] = 1'b1;
         mt_next[t] = (s + 1) % SLOTS;
      end
   endtask

   // ---------------- driver tasks ----------------
   // action: 0 commit, 1 abort, 2 commit+abort together
   task automatic run_request(input int m, input int n, input int action, input int hold);
      int kind, code, lat, t, s, addr, waited;
      logic [31:0] exp_addr;
      predict(m, n, kind, code, lat, t, s, addr);
      if (kind != 2) exp_q.push_back(32'(addr));
      check("ready_before_req", 32'(o_ready), 1);
      i_dim_m = m[DIM_W-1:0];
      i_dim_n = n[DIM_W-1:0];
      i_req   = 1'b1;
      @(posedge clk); #1;
      i_req   = 1'b0;
      i_clear = 1'b0;
      waited  = 0;
      while (!(o_grant || o_error) && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!(o_grant || o_error)) begin
         check("req_timeout", 32'(waited), 32'(lat));
         if (kind != 2) void'(exp_q.pop_front());
         return;
      end
      check("latency", 32'(waited), 32'(lat));
      if (kind == 2) begin
         check("error_pulse", 32'(o_error), 1);
         check("err_code", 32'(o_err_code), 32'(code));
         if (o_grant) begin
            i_abort = 1'b1; @(posedge clk); #1; i_abort = 1'b0;
            return;
         end
         @(posedge clk); #1;
         check("error_one_cycle", 32'(o_error), 0);
         check("ready_after_err", 32'(o_ready), 1);
         check("err_code_held", 32'(o_err_code), 32'(code));
         check("count_after_err", 32'(o_type_count), 32'(m_count));
         return;
      end
      exp_addr = exp_q.pop_front();
      check("grant", 32'(o_grant), 1);
      if (!o_grant) begin
         repeat (2) @(posedge clk);
         #1;
         return;
      end
      check("grant_addr", 32'(o_base_addr), exp_addr);
      check("grant_type", 32'(o_type_idx), 32'(t));
      check("grant_slot", 32'(o_slot_idx), 32'(s));
      check("grant_code_clr", 32'(o_err_code), 0);
      for (int h = 0; h < hold; h++) begin
         i_req = 1'b1;  // must be ignored while busy
         @(posedge clk); #1;
         check("grant_held", 32'(o_grant), 1);
         check("grant_addr_stable", 32'(o_base_addr), exp_addr);
      end
      i_req    = 1'b0;
      i_commit = (action == 0 || action == 2);
      i_abort  = (action != 0);
      @(posedge clk); #1;
      i_commit = 1'b0;
      i_abort  = 1'b0;
      check("ready_after_grant", 32'(o_ready), 1);
      check("grant_dropped", 32'(o_grant), 0);
      if (action == 0) model_commit(kind, m, n, t, s);
      check("type_count", 32'(o_type_count), 32'(m_count));
   endtask

   task automatic do_query(input int t, input int s);
      int ea, em, en, ev;
      i_q_type = t[TW-1:0];
      i_q_slot = s[SW-1:0];
      @(posedge clk); #1;
      if (t < m_count) begin
         ea = (mt_base[t] + s * mt_m[t] * mt_n[t]) % MEM;
         em = mt_m[t]; en = mt_n[t]; ev = mt_valid[t][s];
      end else begin
         ea = 0; em = 0; en = 0; ev = 0;
      end
      check("q_addr", 32'(o_q_addr), 32'(ea));
      check("q_m", 32'(o_q_m), 32'(em));
      check("q_n", 32'(o_q_n), 32'(en));
      check("q_valid", 32'(o_q_valid), 32'(ev));
   endtask

   task automatic do_clear();
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      model_clear();
      check("count_after_clear", 32'(o_type_count), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(o_ready), 1);
      check({tag, "_grant"}, 32'(o_grant), 0);
      check({tag, "_error"}, 32'(o_error), 0);
      check({tag, "_code"}, 32'(o_err_code), 0);
      check({tag, "_count"}, 32'(o_type_count), 0);
      check({tag, "_base"}, 32'(o_base_addr), 0);
      check({tag, "_qvalid"}, 32'(o_q_valid), 0);
      check({tag, "_qaddr"}, 32'(o_q_addr), 0);
   endtask

   task automatic reset_in_grant();
      int waited;
      i_dim_m = 3'd3; i_dim_n = 3'd2; i_req = 1'b1;
      @(posedge clk); #1;
      i_req = 1'b0;
      waited = 0;
      while (!o_grant && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      check("rst_test_grant", 32'(o_grant), 1);
      rst_n = 1'b0;
      #2;
      check_reset_outputs("async_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      check_reset_outputs("after_rst");
      do_query(0, 0);
   endtask

   // ---------------- stimulus ----------------
   int rm, rn, ra;

   initial begin
      rst_n = 1'b0; i_req = 1'b0; i_commit = 1'b0; i_abort = 1'b0; i_clear = 1'b0;
      i_dim_m = '0; i_dim_n = '0; i_q_type = '0; i_q_slot = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // new types, rotation, wrap
      run_request(2, 2, 0, 0);
      run_request(2, 3, 0, 1);
      run_request(2, 2, 0, 0);
      run_request(2, 2, 0, 2);
      do_query(0, 1);
      do_query(1, 1);
      do_query(5, 0);
      // abort then retry; bad dims; commit+abort
      run_request(3, 3, 1, 0);
      run_request(3, 3, 0, 0);
      run_request(0, 2, 0, 0);
      run_request(6, 1, 0, 0);
      run_request(4, 4, 2, 1);
      do_query(3, 0);
      // request wins over a simultaneous clear
      i_clear = 1'b1;
      run_request(2, 3, 0, 0);
      do_clear();

      // table full
      for (int k = 1; k <= 5; k++) run_request(1, k, 0, 0);
      for (int k = 2; k <= 4; k++) run_request(k, 1, 0, 0);
      run_request(2, 2, 0, 0);
      do_query(7, 0);
      do_clear();

      // memory exhausted at free = 220
      run_request(5, 4, 0, 0);
      run_request(4, 5, 0, 0);
      run_request(4, 4, 0, 0);
      run_request(5, 3, 0, 0);
      run_request(3, 5, 0, 0);
      run_request(3, 4, 0, 0);
      run_request(4, 3, 0, 0);
      run_request(5, 5, 0, 0);
      do_query(6, 1);
      do_clear();

      reset_in_grant();

      // random phase
      for (int it = 0; it < 250; it++) begin
         ra = $urandom_range(0, 24);
         if (ra == 0) begin
            do_clear();
         end else if (ra < 4) begin
            do_query($urandom_range(0, MAX_TYPES - 1), $urandom_range(0, SLOTS - 1));
         end else begin
            rm = $urandom_range(1, MAX_DIM);
            rn = $urandom_range(1, MAX_DIM);
            if ($urandom_range(0, 19) == 0) rm = $urandom_range(0, 1) ? 0 : $urandom_range(6, 7);
            if ($urandom_range(0, 19) == 0) rn = $urandom_range(0, 1) ? 0 : $urandom_range(6, 7);
            ra = $urandom_range(0, 9);
            run_request(rm, rn, (ra < 7) ? 0 : (ra < 9) ? 1 : 2, $urandom_range(0, 2));
            do_query($urandom_range(0, MAX_TYPES - 1), $urandom_range(0, SLOTS - 1));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
